// File: rtl/pc_sequencer.sv
// Program-counter sequencer: RUN/FLUSH/HALT control with a circular return-address stack.
// Redirects cost one squashed FLUSH cycle; the stack overwrites its oldest entry on overflow.
module pc_sequencer #(
   parameter int          PC_W      = 8,
   parameter int          RAS_DEPTH = 4,
   parameter int unsigned RESET_VEC = 0
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            enable,
   input  logic            branch,
   input  logic            jump,
   input  logic            call,
   input  logic            ret,
   input  logic [PC_W-1:0] target,
   input  logic            halt,
   input  logic            resume,
   output logic [PC_W-1:0] pc,
   output logic            flush,
   output logic            halted,
   output logic            ras_empty,
   output logic            ras_full,
   output logic            ras_ovf,
   output logic            ras_unf
);

   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FLUSH = 2'd1,
      S_HALT  = 2'd2
   } state_t;

   state_t            r_state, w_state_nx;
   logic [PC_W-1:0]   r_pc, w_pc_nx, w_seq, w_top;
   logic [PTR_W-1:0]  r_sp, w_sp_nx, w_sp_dec, w_wr_addr;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
   logic              r_ovf, w_ovf_nx, r_unf, w_unf_nx;
   logic              r_flush, r_halted;
   logic              w_wr_en, w_empty, w_full;
   logic [PC_W-1:0]   w_wr_data;
   logic [PC_W-1:0]   r_stack [RAS_DEPTH];

   assign w_seq    = r_pc + PC_W'(1);
   assign w_sp_dec = r_sp - PTR_W'(1);
   assign w_top    = r_stack[w_sp_dec];
   assign w_empty  = (r_cnt == CNT_W'(0));
   assign w_full   = (r_cnt == CNT_W'(RAS_DEPTH));

   // Next-state, next-PC and stack-update decode
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_sp_nx    = r_sp;
      w_cnt_nx   = r_cnt;
      w_ovf_nx   = r_ovf;
      w_unf_nx   = r_unf;
      w_wr_en    = 1'b0;
      w_wr_addr  = r_sp;
      w_wr_data  = w_seq;
      if (enable) begin
         case (r_state)
            S_RUN: begin
               if (halt) begin
                  w_state_nx = S_HALT;
               end else if (call && ret) begin
                  // Combined call/return replaces the top entry in place
                  w_state_nx = S_FLUSH;
                  w_pc_nx    = target;
                  w_wr_en    = 1'b1;
                  if (w_empty) begin
                     w_sp_nx  = r_sp + PTR_W'(1);
                     w_cnt_nx = r_cnt + CNT_W'(1);
                  end else begin
                     w_wr_addr = w_sp_dec;
                  end
               end else if (ret) begin
                  w_state_nx = S_FLUSH;
                  if (w_empty) begin
                     w_pc_nx  = w_seq;
                     w_unf_nx = 1'b1;
                  end else begin
                     w_pc_nx  = w_top;
                     w_sp_nx  = w_sp_dec;
                     w_cnt_nx = r_cnt - CNT_W'(1);
                  end
               end else if (call) begin
                  w_state_nx = S_FLUSH;
                  w_pc_nx    = target;
                  w_wr_en    = 1'b1;
                  w_sp_nx    = r_sp + PTR_W'(1);
                  if (w_full) begin
                     w_ovf_nx = 1'b1;
                  end else begin
                     w_cnt_nx = r_cnt + CNT_W'(1);
                  end
               end else if (jump || branch) begin
                  w_state_nx = S_FLUSH;
                  w_pc_nx    = target;
               end else begin
                  w_pc_nx = w_seq;
               end
            end
            S_FLUSH: begin
               w_state_nx = S_RUN;
               w_pc_nx    = w_seq;
            end
            S_HALT: begin
               if (resume) begin
                  w_state_nx = S_RUN;
               end else begin
                  w_state_nx = S_HALT;
               end
            end
            default: begin
               w_state_nx = S_RUN;
            end
         endcase
      end else begin
         w_state_nx = r_state;
      end
   end

   // Control state, PC, stack pointer and sticky flags
   always_ff @(posedge CLK) begin
      if (!reset) begin
         r_state  <= S_RUN;
         r_pc     <= PC_W'(RESET_VEC);
         r_sp     <= '0;
         r_cnt    <= '0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_flush  <= 1'b0;
         r_halted <= 1'b0;
      end else begin
         r_state  <= w_state_nx;
         r_pc     <= w_pc_nx;
         r_sp     <= w_sp_nx;
         r_cnt    <= w_cnt_nx;
         r_ovf    <= w_ovf_nx;
         r_unf    <= w_unf_nx;
         r_flush  <= (w_state_nx == S_FLUSH);
         r_halted <= (w_state_nx == S_HALT);
      end
   end

   // Stack storage; contents are meaningless while occupancy is zero
   always_ff @(posedge CLK) begin
      if (reset && w_wr_en) begin
         r_stack[w_wr_addr] <= w_wr_data;
      end else begin
         r_stack[w_wr_addr] <= r_stack[w_wr_addr];
      end
   end

   assign pc        = r_pc;
   assign flush     = r_flush;
   assign halted    = r_halted;
   assign ras_empty = w_empty;
   assign ras_full  = w_full;
   assign ras_ovf   = r_ovf;
   assign ras_unf   = r_unf;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected outputs queued per driven cycle,
// popped and checked with immediate assertions one time unit after the edge.
module tb_pc_sequencer;

   typedef struct packed {
      logic [7:0] pc;
      logic [5:0] fl;   // {flush, halted, ras_empty, ras_full, ras_ovf, ras_unf}
   } exp_t;

   // Control word bits: {reset_n, enable, branch, jump, call, ret, halt, resume}
   localparam logic [7:0] RN = 8'h80, EN = 8'h40, BR = 8'h20, JP = 8'h10;
   localparam logic [7:0] CA = 8'h08, RE = 8'h04, HA = 8'h02, RS = 8'h01;
   localparam logic [7:0] GO = 8'hC0;

   logic       CLK = 1'b0;
   logic       reset, enable, branch, jump, call, ret, halt, resume;
   logic [7:0] target, pc;
   logic       flush, halted, ras_empty, ras_full, ras_ovf, ras_unf;

   exp_t sb_q[$];
   int   n_eval = 0;
   int   n_fail = 0;

   pc_sequencer #(.PC_W(8), .RAS_DEPTH(4), .RESET_VEC(0)) dut (
      .CLK(CLK), .reset(reset), .enable(enable), .branch(branch), .jump(jump),
      .call(call), .ret(ret), .target(target), .halt(halt), .resume(resume),
      .pc(pc), .flush(flush), .halted(halted), .ras_empty(ras_empty),
      .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 CLK = ~CLK;

   function automatic exp_t ex(input logic [7:0] p, input logic [5:0] f);
      exp_t e;
      e.pc = p;
      e.fl = f;
      return e;
   endfunction

   task automatic step(input logic [7:0] ctl, input logic [7:0] tg, input exp_t e);
      exp_t want;
      logic [5:0] got_fl;
      {reset, enable, branch, jump, call, ret, halt, resume} = ctl;
      target = tg;
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      want   = sb_q.pop_front();
      got_fl = {flush, halted, ras_empty, ras_full, ras_ovf, ras_unf};
      n_eval++;
      assert (pc === want.pc) else begin
         n_fail++;
         $error("FAIL pc: observed %h expected %h", pc, want.pc);
      end
      n_eval++;
      assert (got_fl === want.fl) else begin
         n_fail++;
         $error("FAIL flags @pc=%h: observed %b expected %b", want.pc, got_fl, want.fl);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      {reset, enable, branch, jump, call, ret, halt, resume} = 8'h00;
      target = 8'h00;
      @(negedge CLK);

      step(EN, 8'h00, ex(8'h00, 6'b001000));               // reset state
      for (int i = 1; i <= 256; i++)
         step(GO, 8'h00, ex(8'(i), 6'b001000));           // sequential wrap

      // call/ret round trip and squashed jump in FLUSH
      step(GO | JP, 8'h0F, ex(8'h0F, 6'b101000));
      step(GO,      8'h00, ex(8'h10, 6'b001000));
      step(GO | CA, 8'h40, ex(8'h40, 6'b100000));
      step(GO,      8'h00, ex(8'h41, 6'b000000));
      step(GO,      8'h00, ex(8'h42, 6'b000000));
      step(GO | RE, 8'h00, ex(8'h11, 6'b101000));
      step(GO | JP, 8'h80, ex(8'h12, 6'b001000));

      // halt (wins over jump), stall, resume
      step(GO | JP, 8'h21, ex(8'h21, 6'b101000));
      step(GO,      8'h00, ex(8'h22, 6'b001000));
      step(GO | HA | JP, 8'h99, ex(8'h22, 6'b011000));
      step(RN | RS, 8'h00, ex(8'h22, 6'b011000));
      step(GO,      8'h00, ex(8'h22, 6'b011000));
      step(GO | RS, 8'h00, ex(8'h22, 6'b001000));
      step(GO,      8'h00, ex(8'h23, 6'b001000));
      step(RN | JP, 8'h77, ex(8'h23, 6'b001000));

      // five nested calls overflow a four-entry stack
      step(GO | CA, 8'h50, ex(8'h50, 6'b100000));
      step(GO,      8'h00, ex(8'h51, 6'b000000));
      step(GO | CA, 8'h60, ex(8'h60, 6'b100000));
      step(GO,      8'h00, ex(8'h61, 6'b000000));
      step(GO | CA, 8'h70, ex(8'h70, 6'b100000));
      step(GO,      8'h00, ex(8'h71, 6'b000000));
      step(GO | CA, 8'h80, ex(8'h80, 6'b100100));
      step(GO,      8'h00, ex(8'h81, 6'b000100));
      step(GO | CA, 8'h90, ex(8'h90, 6'b100110));
      step(GO,      8'h00, ex(8'h91, 6'b000110));

      // five returns: last four addresses, then underflow gives pc+1
      step(GO | RE, 8'h00, ex(8'h82, 6'b100010));
      step(GO,      8'h00, ex(8'h83, 6'b000010));
      step(GO | RE, 8'h00, ex(8'h72, 6'b100010));
      step(GO,      8'h00, ex(8'h73, 6'b000010));
      step(GO | RE, 8'h00, ex(8'h62, 6'b100010));
      step(GO,      8'h00, ex(8'h63, 6'b000010));
      step(GO | RE, 8'h00, ex(8'h52, 6'b101010));
      step(GO,      8'h00, ex(8'h53, 6'b001010));
      step(GO | RE, 8'h00, ex(8'h54, 6'b101011));
      step(GO,      8'h00, ex(8'h55, 6'b001011));

      // call+ret together: push when empty, else replace top
      step(GO | CA | RE, 8'hA0, ex(8'hA0, 6'b100011));
      step(GO,           8'h00, ex(8'hA1, 6'b000011));
      step(GO | CA | RE, 8'hB0, ex(8'hB0, 6'b100011));
      step(GO,           8'h00, ex(8'hB1, 6'b000011));
      step(GO | RE,      8'h00, ex(8'hA2, 6'b101011));
      step(GO,           8'h00, ex(8'hA3, 6'b001011));

      // branch, then halt squashed in FLUSH
      step(GO | BR, 8'hC0, ex(8'hC0, 6'b101011));
      step(GO | HA, 8'h00, ex(8'hC1, 6'b001011));
      step(GO,      8'h00, ex(8'hC2, 6'b001011));

      // reset during HALT with three entries, enable low
      step(GO | CA, 8'h10, ex(8'h10, 6'b100011));
      step(GO,      8'h00, ex(8'h11, 6'b000011));
      step(GO | CA, 8'h20, ex(8'h20, 6'b100011));
      step(GO,      8'h00, ex(8'h21, 6'b000011));
      step(GO | CA, 8'h30, ex(8'h30, 6'b100011));
      step(GO,      8'h00, ex(8'h31, 6'b000011));
      step(GO | HA, 8'h00, ex(8'h31, 6'b010011));
      step(8'h00,   8'h00, ex(8'h00, 6'b001000));
      step(GO,      8'h00, ex(8'h01, 6'b001000));

      // reset during FLUSH
      step(GO | JP, 8'h44, ex(8'h44, 6'b101000));
      step(EN,      8'h00, ex(8'h00, 6'b001000));
      step(GO,      8'h00, ex(8'h01, 6'b001000));

      n_eval++;
      assert (sb_q.size() == 0) else begin
         n_fail++;
         $error("FAIL scoreboard: observed %0d leftover entries expected 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 8, giving the program-counter width in bits.
REQ-002 SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_VEC, default 0, giving the PC value loaded at reset.
REQ-004 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-low reset; one clock, reset is synchronous and active-low.
REQ-006 SHALL have port enable, input, 1, advance when 1, hold all state when 0.
REQ-007 SHALL have port branch, input, 1, branch instruction whose condition is met.
REQ-008 SHALL have port jump, input, 1, unconditional jump.
REQ-009 SHALL have port call, input, 1, jump to target and push the return address.
REQ-010 SHALL have port ret, input, 1, pop the return address and go to it.
REQ-011 SHALL have port target, input, PC_W, redirect address for branch/jump/call.
REQ-012 SHALL have port halt, input, 1, enter HALT.
REQ-013 SHALL have port resume, input, 1, leave HALT.
REQ-014 SHALL have port pc, output, PC_W, current fetch address (registered).
REQ-015 SHALL have port flush, output, 1, registered; high while in FLUSH.
REQ-016 SHALL have port halted, output, 1, high while in HALT.
REQ-017 SHALL have ports ras_empty and ras_full, output, 1 each, stack occupancy flags.
REQ-018 SHALL have ports ras_ovf and ras_unf, output, 1 each, sticky overflow/underflow flags.

Function
REQ-019 SHALL implement states RUN, FLUSH and HALT.
REQ-020 SHALL compute the sequential address as pc+1 modulo 2^PC_W, so all-ones wraps to 0.
REQ-021 SHALL, in RUN with enable=1, choose the next PC by this priority:
- halt: go to HALT, pc held
- ret: pc <= stack top, pop
- call: pc <= target, push pc+1
- jump or branch: pc <= target
- otherwise: pc <= pc+1
REQ-022 SHALL move RUN -> FLUSH for exactly one enabled cycle after any ret, call, jump or branch is taken.
REQ-023 SHALL, in FLUSH with enable=1, set pc <= pc+1, ignore branch/jump/call/ret/halt as squashed, and return to RUN.
REQ-024 SHALL, in HALT, hold pc, and move to RUN with pc unchanged on resume=1 with enable=1.
REQ-025 SHALL, when enable=0, hold pc, state, stack, pointer and flags unchanged in every state.
REQ-026 SHALL, when call and ret are both high in RUN, set pc <= target, overwrite the stack top with pc+1, and leave occupancy unchanged; if the stack is empty, push instead.
REQ-027 SHALL, on a push when full, overwrite the oldest entry (circular), keep ras_full=1, and set ras_ovf.
REQ-028 SHALL, on a pop when empty, set pc <= pc+1, leave the stack unchanged, set ras_unf, and still enter FLUSH.
REQ-029 SHALL assert ras_empty when occupancy=0 and ras_full when occupancy=RAS_DEPTH, as combinational functions of registered occupancy.
REQ-030 SHALL keep ras_ovf and ras_unf asserted until reset.

Reset
REQ-031 SHALL, on a rising CLK edge with reset=0 and regardless of enable or state, set pc=RESET_VEC, state=RUN, occupancy 0, flush=0, halted=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0.
REQ-032 SHALL abort a FLUSH or HALT in progress on reset, with no residual effect.

Verification
REQ-033 SHALL cover sequential wrap: PC_W=8, run from reset with no redirects for 256 cycles -> pc 0..255 then 0; flush stays 0.
REQ-034 SHALL cover call/ret: call target=0x40 at pc=0x10 -> pc=0x40, flush=1 next cycle; later ret -> pc=0x11, ras_empty=1.
REQ-035 SHALL cover overflow: RAS_DEPTH=4, five nested calls (FLUSH cycles between them) -> ras_ovf=1; five rets return the last four addresses, then the fifth sets ras_unf=1 and gives pc+1.
REQ-036 SHALL cover a squashed redirect: jump target=0x80 while in FLUSH -> ignored, pc=previous+1.
REQ-037 SHALL cover halt and stall: halt at pc=0x22 -> pc stays 0x22, halted=1; enable=0 with resume=1 -> no change; enable=1 with resume=1 -> RUN, next pc=0x23.
REQ-038 SHALL cover reset mid-operation: reset=0 during HALT with 3 stack entries -> pc=RESET_VEC, halted=0, ras_empty=1, sticky flags cleared.
